// File: rtl/can_frame_tx.sv
`default_nettype none
// ============================================================================
// can_frame_tx : CAN 2.0A/2.0B bit-level frame transmitter (CRC-15, stuffing,
//                arbitration and ACK monitoring).                   Rev 1.0
// ============================================================================
module can_frame_tx #(
  parameter int IFS_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        rx,
  input  logic        start,
  input  logic        ide,
  input  logic [28:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        ack_ok,
  output logic        arb_lost
);

  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_WAIT    = 5'd1,
    ST_SOF     = 5'd2,
    ST_BASE_ID = 5'd3,
    ST_SRR_RTR = 5'd4,
    ST_IDE     = 5'd5,
    ST_EXT_ID  = 5'd6,
    ST_RTR     = 5'd7,
    ST_R1      = 5'd8,
    ST_R0      = 5'd9,
    ST_DLC     = 5'd10,
    ST_DATA    = 5'd11,
    ST_CRC     = 5'd12,
    ST_CRC_DEL = 5'd13,
    ST_ACK     = 5'd14,
    ST_ACK_DEL = 5'd15,
    ST_EOF     = 5'd16,
    ST_IFS     = 5'd17
  } state_t;

  // state/cnt name the last non-stuff bit put on tx; is_stuff marks a stuff bit on tx
  state_t      state;
  logic [5:0]  cnt;
  logic        is_stuff;
  logic [2:0]  run;
  logic [14:0] crc;

  logic        ide_l;
  logic [28:0] id_l;
  logic        rtr_l;
  logic [3:0]  dlc_l;
  logic [63:0] data_l;

  logic [3:0]  nbytes;
  logic [6:0]  data_bits;
  logic        crc_scope;
  logic        stuff_zone;
  logic        arb_zone;
  logic        need_stuff;
  logic        arb_loss;
  logic [14:0] crc_upd;
  logic [14:0] crc_cur;
  state_t      adv_state;
  logic [5:0]  adv_cnt;
  logic        finish;
  logic        adv_bit;

  assign nbytes     = rtr_l ? 4'd0 : ((dlc_l > 4'd8) ? 4'd8 : dlc_l);
  assign data_bits  = {nbytes, 3'b000};
  assign crc_scope  = (state >= ST_SOF) && (state <= ST_DATA);
  assign stuff_zone = (state >= ST_SOF) && (state <= ST_CRC);
  assign arb_zone   = (state == ST_BASE_ID) || (state == ST_SRR_RTR) || (state == ST_IDE) ||
                      (state == ST_EXT_ID)  || (state == ST_RTR);
  assign need_stuff = stuff_zone && !is_stuff && (run == 3'd5);
  assign arb_loss   = arb_zone && !is_stuff && tx && !rx;
  assign crc_upd    = {crc[13:0], 1'b0} ^ ((tx ^ crc[14]) ? 15'h4599 : 15'h0000);
  // the first CRC bit leaves on the same edge that folds in the last covered bit
  assign crc_cur    = (crc_scope && !is_stuff) ? crc_upd : crc;

  always_comb begin
    adv_state = state;
    adv_cnt   = 6'd0;
    finish    = 1'b0;
    case (state)
      ST_WAIT:    adv_state = ST_SOF;
      ST_SOF:     adv_state = ST_BASE_ID;
      ST_BASE_ID: if (cnt != 6'd10) adv_cnt = cnt + 6'd1; else adv_state = ST_SRR_RTR;
      ST_SRR_RTR: adv_state = ST_IDE;
      ST_IDE:     adv_state = ide_l ? ST_EXT_ID : ST_R0;
      ST_EXT_ID:  if (cnt != 6'd17) adv_cnt = cnt + 6'd1; else adv_state = ST_RTR;
      ST_RTR:     adv_state = ST_R1;
      ST_R1:      adv_state = ST_R0;
      ST_R0:      adv_state = ST_DLC;
      ST_DLC: begin
        if (cnt != 6'd3) adv_cnt = cnt + 6'd1;
        else adv_state = (nbytes == 4'd0) ? ST_CRC : ST_DATA;
      end
      ST_DATA:    if ({1'b0, cnt} != data_bits - 7'd1) adv_cnt = cnt + 6'd1; else adv_state = ST_CRC;
      ST_CRC:     if (cnt != 6'd14) adv_cnt = cnt + 6'd1; else adv_state = ST_CRC_DEL;
      ST_CRC_DEL: adv_state = ST_ACK;
      ST_ACK:     adv_state = ST_ACK_DEL;
      ST_ACK_DEL: adv_state = ST_EOF;
      ST_EOF: begin
        if (cnt != 6'd6) adv_cnt = cnt + 6'd1;
        else if (IFS_BITS == 0) finish = 1'b1;
        else adv_state = ST_IFS;
      end
      ST_IFS:     if (int'(cnt) != IFS_BITS - 1) adv_cnt = cnt + 6'd1; else finish = 1'b1;
      default:    adv_state = ST_IDLE;
    endcase
  end

  always_comb begin
    adv_bit = 1'b1;
    case (adv_state)
      ST_SOF:        adv_bit = 1'b0;
      ST_BASE_ID:    adv_bit = id_l[5'd28 - adv_cnt[4:0]];
      ST_SRR_RTR:    adv_bit = ide_l ? 1'b1 : rtr_l;
      ST_IDE:        adv_bit = ide_l;
      ST_EXT_ID:     adv_bit = id_l[5'd17 - adv_cnt[4:0]];
      ST_RTR:        adv_bit = rtr_l;
      ST_R1, ST_R0:  adv_bit = 1'b0;
      ST_DLC:        adv_bit = dlc_l[2'd3 - adv_cnt[1:0]];
      ST_DATA:       adv_bit = data_l[6'd63 - adv_cnt];
      ST_CRC:        adv_bit = crc_cur[4'd14 - adv_cnt[3:0]];
      default:       adv_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 6'd0;
      is_stuff <= 1'b0;
      run      <= 3'd0;
      crc      <= 15'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_ok   <= 1'b0;
      arb_lost <= 1'b0;
      ide_l    <= 1'b0;
      id_l     <= 29'd0;
      rtr_l    <= 1'b0;
      dlc_l    <= 4'd0;
      data_l   <= 64'd0;
    end else begin
      done     <= 1'b0;
      arb_lost <= 1'b0;
      if (!busy) begin
        if (start) begin
          ide_l    <= ide;
          id_l     <= id;
          rtr_l    <= rtr;
          dlc_l    <= dlc;
          data_l   <= data;
          busy     <= 1'b1;
          ack_ok   <= 1'b0;
          state    <= ST_WAIT;
          cnt      <= 6'd0;
          is_stuff <= 1'b0;
          crc      <= 15'd0;
        end
      end else if (en) begin
        if (arb_loss) begin
          arb_lost <= 1'b1;
          busy     <= 1'b0;
          tx       <= 1'b1;
          state    <= ST_IDLE;
        end else begin
          if (state == ST_ACK) ack_ok <= !rx;
          if (crc_scope && !is_stuff) crc <= crc_upd;
          if (finish) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            tx    <= 1'b1;
            state <= ST_IDLE;
          end else if (need_stuff) begin
            tx       <= ~tx;
            is_stuff <= 1'b1;
            run      <= 3'd1;
          end else begin
            state    <= adv_state;
            cnt      <= adv_cnt;
            is_stuff <= 1'b0;
            tx       <= adv_bit;
            run      <= (adv_bit == tx) ? ((run == 3'd7) ? run : run + 3'd1) : 3'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
